alu_cmd_loader: RTL

- Front end for the 4-bit ALU/seven-segment path; it is the operand source that drives the ALU's inputs.
- Converts raw board switches and two raw push-buttons into one complete ALU command {a, b, op}.
- Debounces both buttons and sequences operand entry with a small FSM.
- Presents the finished command on a valid/ready handshake to the ALU stage, which registers it.

---
 rtl/alu_cmd_loader.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_loader.sv
// alu_cmd_loader -- operand source for the 4-bit ALU / seven-segment path.
//
// Turns raw board switches plus two raw push-buttons into a complete ALU
// command {cmd_a, cmd_b, cmd_op}. The user enters A, then B, then the opcode
// by pressing "next". The finished command is offered on a valid/ready
// handshake. "clear" aborts entry at any point and zeroes the command.
//
// Build option:
//   ALU_CMD_LOADER_REPEAT_EN  when defined, a completed transfer returns to
//                             opcode entry with A and B retained, so the same
//                             operands can be re-issued with a new opcode.
//                             When undefined, a transfer returns to A entry.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   sw         raw switch bus (DW bits), quasi-static
//   btn_next   raw enter/advance button, active-high, asynchronous
//   btn_clr    raw clear button, active-high, asynchronous
//   cmd_valid  command available (registered)
//   cmd_ready  consumer accepts the command
//   cmd_a      operand A (DW bits)
//   cmd_b      operand B (DW bits)
//   cmd_op     ALU opcode (OPW bits)
//   state_dbg  current entry state, for the LED display

// Per-button synchronizer + debouncer. Emits a one-cycle registered pulse on
// each debounced press; release produces no pulse.
module alu_cmd_loader_deb #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);
    localparam int CW = $clog2(DEB_CYCLES);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            rise <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                // This is the DEB_CYCLES-th consecutive differing cycle.
                level <= ~level;
                cnt   <= '0;
                rise  <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module alu_cmd_loader #(
    parameter int DW         = 4,
    parameter int OPW        = 3,
    parameter int DEB_CYCLES = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [DW-1:0]  sw,
    input  logic           btn_next,
    input  logic           btn_clr,
    output logic           cmd_valid,
    input  logic           cmd_ready,
    output logic [DW-1:0]  cmd_a,
    output logic [DW-1:0]  cmd_b,
    output logic [OPW-1:0] cmd_op,
    output logic [1:0]     state_dbg
);
    typedef enum logic [1:0] {
        S_A     = 2'b00,
        S_B     = 2'b01,
        S_OP    = 2'b10,
        S_ISSUE = 2'b11
    } state_t;

    state_t        state;
    logic [DW-1:0] sw_s1, sw_sync;
    logic [1:0]    btn_raw;
    logic [1:0]    btn_rise;
    logic          nxt_p, clr_p;

    // Switches only need synchronizing; they are sampled on a debounced press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1   <= '0;
            sw_sync <= '0;
        end else begin
            sw_s1   <= sw;
            sw_sync <= sw_s1;
        end
    end

    // Index 0 = next, 1 = clear; both buttons are debounced independently.
    assign btn_raw = {btn_clr, btn_next};

    for (genvar i = 0; i < 2; i++) begin : g_btn
        alu_cmd_loader_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (btn_raw[i]),
            .rise (btn_rise[i])
        );
    end

    assign nxt_p = btn_rise[0];
    assign clr_p = btn_rise[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_A;
            cmd_valid <= 1'b0;
            cmd_a     <= '0;
            cmd_b     <= '0;
            cmd_op    <= '0;
        end else if (clr_p) begin
            // Clear wins over next. A transfer coincident with clear has
            // already been sampled by the consumer, so dropping it is safe.
            state     <= S_A;
            cmd_valid <= 1'b0;
            cmd_a     <= '0;
            cmd_b     <= '0;
            cmd_op    <= '0;
        end else begin
            case (state)
                S_A: if (nxt_p) begin
                    cmd_a <= sw_sync;
                    state <= S_B;
                end
                S_B: if (nxt_p) begin
                    cmd_b <= sw_sync;
                    state <= S_OP;
                end
                S_OP: if (nxt_p) begin
                    cmd_op    <= sw_sync[OPW-1:0];
                    cmd_valid <= 1'b1;
                    state     <= S_ISSUE;
                end
                S_ISSUE: if (cmd_ready) begin
                    // Operands stay put during a stall; nxt_p is ignored here.
                    cmd_valid <= 1'b0;
`ifdef ALU_CMD_LOADER_REPEAT_EN
                    state     <= S_OP;
`else
                    state     <= S_A;
`endif
                end
            endcase
        end
    end

    assign state_dbg = state;
endmodule
